hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Execute-stage multiply/divide unit, directly downstream of the register file.
- Consumes the two source-read values (rs, rt) on a start pulse and runs a 32-iteration shift-add multiply or restoring divide.
- Writes the 64-bit result into the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
- Stalls the pipeline through busy until done.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. The iteration count equals DATA_WIDTH; the counter is clog2(DATA_WIDTH)+1 bits.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- w_data_s1val_32  input  DATA_WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source)
- w_data_s2val_32  input  DATA_WIDTH  rt value (multiplier / divisor)
- mthi  input  1  write rs value into HI
- mtlo  input  1  write rs value into LO
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when HI/LO hold a new result
- div_by_zero  output  1  pulses with done when a DIV/DIVU had divisor 0
- hi  output  DATA_WIDTH  HI register
- lo  output  DATA_WIDTH  LO register

Behaviour:
- Reset is asynchronous, active-low, one clock domain. While reset_n=0:
  - state=IDLE, counter=0
  - busy=0, done=0, div_by_zero=0, hi=0, lo=0
  - all internal operand, accumulator and sign registers are 0
- Reset asserted mid-operation aborts the operation. No partial result reaches HI/LO.
- FSM states: IDLE, RUN, FIXUP.
- IDLE:
  - On an edge with start=1 (edge E0), latch op and both operands and go to RUN with counter=0.
  - For signed ops, latch absolute values and record the result sign(s).
  - If start=0, mthi/mtlo write HI/LO from w_data_s1val_32 on the edge.
  - mthi and mtlo asserted together write both.
  - start and mthi/mtlo asserted together: start wins; the move is ignored.
- RUN:
  - One iteration per edge, E1..E32. Multiply: conditional add then right shift. Divide: restoring subtract and quotient bit shift-in.
  - After the 32nd iteration (E32), go to FIXUP.
- FIXUP, edge E33:
  - Apply sign correction, write HI/LO, go to IDLE.
  - done=1 and div_by_zero (if applicable) for exactly the cycle after E33.
- busy=1 from E0 up to E33, combinationally equal to (state != IDLE).
- Latency: the result is visible on hi/lo and done=1 33 cycles after the start edge. The next start is accepted on the E33+1 edge.
- start, mthi and mtlo are ignored while busy. HI/LO hold their previous values until E33.
- Result mapping:
  - MULT/MULTU: {hi,lo} = 64-bit product. MULT negates the magnitude product when operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed quotient is negated when signs differ; remainder takes the dividend's sign.
- Boundary cases:
  - Divide by zero (either op): lo=0xFFFFFFFF, hi=dividend as presented (unmodified rs), no sign fixup, div_by_zero=1 with done. Full 33-cycle latency is kept.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, div_by_zero=0.
  - MULT 0x80000000 * 0x80000000: hi=0x40000000, lo=0x00000000.
- Arithmetic is on a 64-bit accumulator for multiply. Divide uses a 33-bit partial remainder. No output is X after reset.

Test Plan:
- Reset, then MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy for 33 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 100/7 -> lo=14, hi=2. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=5 rt=0 -> after 33 cycles lo=0xFFFFFFFF, hi=5; div_by_zero=1 only in the done cycle.
- Start DIVU, then pulse start (different operands) and mthi (rs=0x1234) mid-run -> both ignored; only the first result appears. Afterwards mthi rs=0x1234 -> hi=0x1234 next edge, lo unchanged. start+mtlo together -> operation starts, LO not written.
- Drive reset_n=0 asynchronously at cycle 10 of a DIV -> busy, done, hi, lo are 0 immediately without a clock edge. After release, MULTU 3*4 -> hi=0, lo=12 with normal 33-cycle latency.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: execute-stage multiply/divide unit with architectural HI/LO registers.
//
// Runs a DATA_WIDTH-iteration shift-add multiply (MULT/MULTU) or restoring divide (DIV/DIVU)
// on the rs/rt values presented with a start pulse, then writes the result into HI/LO.
// Also serves MTHI/MTLO writes while idle. HI/LO are outputs, so MFHI/MFLO read them directly.
//
// Ports:
//   clock            rising-edge clock
//   reset_n          asynchronous active-low reset
//   start            begin an operation (sampled only while idle)
//   op               00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   w_data_s1val_32  rs value: multiplicand / dividend / MTHI-MTLO source
//   w_data_s2val_32  rt value: multiplier / divisor
//   mthi, mtlo       write rs into HI / LO (idle and start=0 only)
//   busy             operation in flight (state != IDLE)
//   done             one-cycle pulse when HI/LO hold a new result
//   div_by_zero      pulses with done when a divide had a zero divisor
//   hi, lo           HI and LO registers
module hilo_muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] w_data_s1val_32,
    input  logic [DATA_WIDTH-1:0] w_data_s2val_32,
    input  logic                  mthi,
    input  logic                  mtlo,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFixup} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    // Multiply: full product accumulator, multiplier shifted out of the low half.
    // Divide: low half holds the dividend shifting out / quotient shifting in.
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W:0]       rem_q, rem_d;
    logic [W-1:0]     opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [W-1:0]     raw_a_q, raw_a_d;    // rs as presented, for the divide-by-zero HI value
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_zero_q, div_zero_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_pulse_q, dbz_pulse_d;

    // Combinational helpers
    logic             is_signed;
    logic             a_neg, b_neg;
    logic [W-1:0]     mag_a, mag_b;
    logic [W:0]       shifted, diff, sum;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     quo, rem_fix;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        opnd_d      = opnd_q;
        raw_a_d     = raw_a_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        div_zero_d  = div_zero_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        dbz_pulse_d = 1'b0;

        is_signed = ~op[0];
        a_neg     = is_signed & w_data_s1val_32[W-1];
        b_neg     = is_signed & w_data_s2val_32[W-1];
        mag_a     = a_neg ? ('0 - w_data_s1val_32) : w_data_s1val_32;
        mag_b     = b_neg ? ('0 - w_data_s2val_32) : w_data_s2val_32;

        shifted   = {rem_q[W-1:0], acc_q[W-1]};
        diff      = shifted - {1'b0, opnd_q};
        sum       = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        prod      = neg_res_q ? ('0 - acc_q) : acc_q;
        quo       = neg_res_q ? ('0 - acc_q[W-1:0]) : acc_q[W-1:0];
        rem_fix   = neg_rem_q ? ('0 - rem_q[W-1:0]) : rem_q[W-1:0];

        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d       = op;
                    cnt_d      = '0;
                    raw_a_d    = w_data_s1val_32;
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = op[1] & (w_data_s2val_32 == '0);
                    rem_d      = '0;
                    opnd_d     = op[1] ? mag_b : mag_a;
                    acc_d      = {{W{1'b0}}, (op[1] ? mag_a : mag_b)};
                    state_d    = StRun;
                end else begin
                    if (mthi) hi_d = w_data_s1val_32;
                    if (mtlo) lo_d = w_data_s1val_32;
                end
            end

            StRun: begin
                if (op_q[1]) begin
                    // Restoring step: keep the subtraction only if it did not go negative.
                    if (!diff[W]) begin
                        rem_d = diff;
                        acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b1};
                    end else begin
                        rem_d = shifted;
                        acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b0};
                    end
                end else begin
                    // Carry out of the add becomes the new top bit after the shift.
                    acc_d = {sum, acc_q[W-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = StFixup;
                end
            end

            StFixup: begin
                state_d = StIdle;
                cnt_d   = '0;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    if (div_zero_q) begin
                        lo_d        = '1;
                        hi_d        = raw_a_q;
                        dbz_pulse_d = 1'b1;
                    end else begin
                        lo_d = quo;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod[2*W-1:W];
                    lo_d = prod[W-1:0];
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            opnd_q      <= '0;
            raw_a_q     <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
            dbz_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            opnd_q      <= opnd_d;
            raw_a_q     <= raw_a_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            div_zero_q  <= div_zero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
            dbz_pulse_q <= dbz_pulse_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_pulse_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Testbench for hilo_muldiv_unit: scoreboard of expected HI/LO/div_by_zero results,
// popped and compared whenever the DUT pulses done.
module tb_hilo_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } result_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    result_t     sb_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    int          num_checks;
    int          num_errors;

    hilo_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .op              (op),
        .w_data_s1val_32 (s1),
        .w_data_s2val_32 (s2),
        .mthi            (mthi),
        .mtlo            (mtlo),
        .busy            (busy),
        .done            (done),
        .div_by_zero     (div_by_zero),
        .hi              (hi),
        .lo              (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expected result.
    always @(negedge clock) begin
        if (reset_n && done) begin
            if (sb_q.size() == 0) begin
                check_eq("done_unexpected", 64'(done), 64'(0));
            end else begin
                result_t r;
                r = sb_q.pop_front();
                check_eq("res_hi", 64'(hi), 64'(r.hi));
                check_eq("res_lo", 64'(lo), 64'(r.lo));
                check_eq("res_dbz", 64'(div_by_zero), 64'(r.dbz));
                model_hi = r.hi;
                model_lo = r.lo;
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic mv_lo, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dbz);
        result_t r;
        @(negedge clock);
        op    = o;
        s1    = a;
        s2    = b;
        start = 1'b1;
        mtlo  = mv_lo;
        r.hi  = exp_hi;
        r.lo  = exp_lo;
        r.dbz = exp_dbz;
        sb_q.push_back(r);
        @(posedge clock);
        #1;
        start = 1'b0;
        mtlo  = 1'b0;
        check_eq("busy_e0", 64'(busy), 64'(1));
        if (mv_lo) check_eq("lo_no_move", 64'(lo), 64'(model_lo));
    endtask

    task automatic wait_done(input bit inject);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
            if (inject && cyc == 5) begin
                start = 1'b1;
                op    = OP_MULTU;
                s1    = 32'h1234;
                s2    = 32'h99;
                mthi  = 1'b1;
            end
            if (inject && cyc == 6) begin
                start = 1'b0;
                mthi  = 1'b0;
            end
            if (inject && cyc == 10) check_eq("hold_hi", 64'(hi), 64'(model_hi));
            if (cyc == 1 || cyc == 32) check_eq("busy_run", 64'(busy), 64'(1));
            if (done) seen = 1'b1;
        end
        check_eq("latency", 64'(cyc), 64'(33));
        check_eq("busy_done", 64'(busy), 64'(0));
        @(posedge clock);
        #1;
        check_eq("done_pulse", 64'(done), 64'(0));
        check_eq("dbz_after", 64'(div_by_zero), 64'(0));
    endtask

    task automatic move(input logic to_hi, input logic to_lo, input logic [31:0] val);
        @(negedge clock);
        s1   = val;
        mthi = to_hi;
        mtlo = to_lo;
        @(posedge clock);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        if (to_hi) model_hi = val;
        if (to_lo) model_lo = val;
        check_eq("move_hi", 64'(hi), 64'(model_hi));
        check_eq("move_lo", 64'(lo), 64'(model_lo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        num_checks = 0;
        num_errors = 0;
        model_hi   = '0;
        model_lo   = '0;
        reset_n    = 1'b0;
        start      = 1'b0;
        op         = '0;
        s1         = '0;
        s2         = '0;
        mthi       = 1'b0;
        mtlo       = 1'b0;
        #1;
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_dbz", 64'(div_by_zero), 64'(0));
        check_eq("rst_hilo", {hi, lo}, 64'(0));
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_done(1'b0);
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        wait_done(1'b0);
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0, 1'b0);
        wait_done(1'b0);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done(1'b0);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0);
        wait_done(1'b0);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 1'b0);
        wait_done(1'b0);
        issue(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, 32'd2, 32'hFFFF_FFF2, 1'b0);
        wait_done(1'b0);
        issue(OP_DIVU, 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        wait_done(1'b0);
        issue(OP_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        wait_done(1'b0);

        // Mid-run start and mthi are ignored; only the first result lands.
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0);
        wait_done(1'b1);

        move(1'b1, 1'b0, 32'h1234);
        move(1'b1, 1'b1, 32'hCAFE_0001);

        // start with mtlo: the operation runs, LO is not written from rs.
        issue(OP_MULTU, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 1'b0);
        wait_done(1'b0);
        move(1'b1, 1'b0, 32'hABCD);

        // Asynchronous reset mid-divide clears everything without a clock edge.
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
        repeat (10) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy), 64'(0));
        check_eq("arst_done", 64'(done), 64'(0));
        check_eq("arst_hilo", {hi, lo}, 64'(0));
        sb_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        issue(OP_MULTU, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12, 1'b0);
        wait_done(1'b0);

        check_eq("sb_drain", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
